// File: rtl/config_pkg.sv
// -----------------------------------------------------------------------------
// config_pkg
// Shared definitions for the configuration path: word geometry, the packer
// state enumeration and the bitstream sync word used when building streams.
// -----------------------------------------------------------------------------
package config_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int BYTES_PER_WORD = 4;

  // Marks the start of a configuration bitstream.
  localparam logic [WORD_WIDTH-1:0] CONFIG_SYNC_WORD = 32'hFAB0_FAB1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } packer_state_e;

endpackage

// File: rtl/config_idle_timer.sv
// -----------------------------------------------------------------------------
// config_idle_timer
// Counts idle cycles of a configuration session. A kick (byte received)
// reloads the count to zero; while disabled the count is held at zero.
// expire flags the last idle cycle of the session. It is combinational so
// the packer can leave ACTIVE on the same edge.
//
// Ports
//   CLK     in   system clock, rising edge
//   reset   in   synchronous, active-high reset
//   kick    in   byte received this cycle; reloads the count
//   enable  in   packer is ACTIVE
//   expire  out  count at terminal value with no kick this cycle
// -----------------------------------------------------------------------------
module config_idle_timer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic CLK,
  input  logic reset,
  input  logic kick,
  input  logic enable,
  output logic expire
);

  // Count reaches at most TIMEOUT_CYCLES-1 (on the expiry edge), so
  // clog2(TIMEOUT_CYCLES) bits are enough.
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] count;

  always_ff @(posedge CLK) begin
    if (reset || !enable || kick) begin
      count <= '0;
    end else if (count != {CW{1'b1}}) begin
      count <= count + CW'(1);
    end
  end

  // Gated by enable so a TIMEOUT_CYCLES of 2 (terminal value 0) does not
  // flag while the packer sits in IDLE with the count held at zero.
  assign expire = enable && !kick && (count == TERMINAL);

endmodule

// File: rtl/config_word_packer.sv
// -----------------------------------------------------------------------------
// config_word_packer
// Packs the UART byte stream MSB-first into 32-bit configuration words and
// frames sessions: ComActive rises on the first byte and falls after an idle
// timeout, dropping any partial word. A session checksum and a saturating
// word count are kept for host readback and hold their values in IDLE.
//
// Ports
//   CLK          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   RxData[7:0]  in   received byte
//   RxValid      in   one-cycle qualifier for RxData
//   WriteData    out  assembled word, first byte in [31:24]
//   WriteStrobe  out  one-cycle pulse with each new WriteData
//   ComActive    out  session active (config FSM reset)
//   BytePhase    out  bytes of the current word already received
//   Checksum     out  mod-256 byte sum of the current/last session
//   WordCount    out  words emitted this session, saturating
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no session; next byte starts one, readback values held
// ACTIVE | session open; bytes packed, idle timer running
// -----------------------------------------------------------------------------
module config_word_packer
  import config_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [7:0]             RxData,
  input  logic                   RxValid,
  output logic [WORD_WIDTH-1:0]  WriteData,
  output logic                   WriteStrobe,
  output logic                   ComActive,
  output logic [1:0]             BytePhase,
  output logic [7:0]             Checksum,
  output logic [COUNT_WIDTH-1:0] WordCount
);

  localparam logic [1:0] LAST_PHASE = 2'(BYTES_PER_WORD - 1);
  localparam int         SHIFT_W    = WORD_WIDTH - 8;

  packer_state_e state, state_nxt;

  logic               expire;
  logic               start_session;
  logic               take_byte;
  logic               word_done;
  logic               drop_partial;
  logic [SHIFT_W-1:0] shift_q;

  config_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .CLK    (CLK),
    .reset  (reset),
    .kick   (RxValid),
    .enable (state == ACTIVE),
    .expire (expire)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; expire is already false when a byte arrives, so a
  // byte on the expiry cycle keeps the session open.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (RxValid) state_nxt = ACTIVE;
      ACTIVE:  if (expire)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath controls decoded from the state
  always_comb begin
    start_session = 1'b0;
    take_byte     = 1'b0;
    word_done     = 1'b0;
    drop_partial  = 1'b0;
    case (state)
      IDLE: begin
        start_session = RxValid;
      end
      ACTIVE: begin
        take_byte    = RxValid;
        word_done    = RxValid && (BytePhase == LAST_PHASE);
        drop_partial = expire;
      end
      default: ;
    endcase
  end

  // Registered outputs and packing datapath. ComActive decodes the next
  // state so it rises the cycle after the first byte, giving the config
  // FSM its reset edge well before the earliest strobe.
  always_ff @(posedge CLK) begin
    if (reset) begin
      ComActive   <= 1'b0;
      WriteStrobe <= 1'b0;
      WriteData   <= '0;
      shift_q     <= '0;
      BytePhase   <= '0;
      Checksum    <= '0;
      WordCount   <= '0;
    end else begin
      ComActive   <= (state_nxt == ACTIVE);
      WriteStrobe <= word_done;

      if (word_done) begin
        WriteData <= {shift_q, RxData};
      end

      if (start_session) begin
        shift_q   <= {{(SHIFT_W-8){1'b0}}, RxData};
        Checksum  <= RxData;
        WordCount <= '0;
        BytePhase <= 2'd1;
      end else if (take_byte) begin
        shift_q  <= {shift_q[SHIFT_W-9:0], RxData};
        Checksum <= Checksum + RxData;
        if (word_done) begin
          BytePhase <= '0;
          if (WordCount != {COUNT_WIDTH{1'b1}}) begin
            WordCount <= WordCount + COUNT_WIDTH'(1);
          end
        end else begin
          BytePhase <= BytePhase + 2'd1;
        end
      end else if (drop_partial) begin
        // Partial word is abandoned; shift_q is overwritten by the next
        // four bytes before it is ever used, so it is left as is.
        BytePhase <= '0;
      end
    end
  end

endmodule

// File: tb/tb_config_word_packer.sv
module tb_config_word_packer;

  localparam int T  = 8;
  localparam int CW = 2;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    RxData = 8'h00;
  logic          RxValid = 1'b0;
  logic [31:0]   WriteData;
  logic          WriteStrobe;
  logic          ComActive;
  logic [1:0]    BytePhase;
  logic [7:0]    Checksum;
  logic [CW-1:0] WordCount;

  config_word_packer #(
    .TIMEOUT_CYCLES(T),
    .COUNT_WIDTH(CW)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .RxData     (RxData),
    .RxValid    (RxValid),
    .WriteData  (WriteData),
    .WriteStrobe(WriteStrobe),
    .ComActive  (ComActive),
    .BytePhase  (BytePhase),
    .Checksum   (Checksum),
    .WordCount  (WordCount)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: session membership is decided purely from the
  // distance to the most recent byte; a session is open at cycle k when the
  // last byte before k arrived 1..T-1 cycles earlier.
  int          cyc = 0;
  int          last_byte = -1000;
  int          sess_bytes = 0;
  int          sum = 0;
  int          words = 0;
  logic [31:0] word_acc = '0;
  logic [31:0] m_wdata = '0;
  logic        m_strobe = 1'b0;
  logic [31:0] seen_words[$];

  function automatic bit open_at(input int k);
    return (k - last_byte >= 1) && (k - last_byte <= T - 1);
  endfunction

  initial begin
    logic       s_rst, s_v;
    logic [7:0] s_d;
    bit         com_exp;
    forever begin
      @(posedge CLK);
      s_rst = reset; s_v = RxValid; s_d = RxData;
      if (s_rst) begin
        last_byte = -1000; sess_bytes = 0; sum = 0; words = 0;
        word_acc = '0; m_wdata = '0; m_strobe = 1'b0;
      end else begin
        m_strobe = 1'b0;
        if (s_v) begin
          if (!open_at(cyc)) begin
            sess_bytes = 0; sum = 0; words = 0; word_acc = '0;
          end
          sess_bytes++;
          sum = (sum + int'(s_d)) % 256;
          word_acc = {word_acc[23:0], s_d};
          if (sess_bytes % 4 == 0) begin
            m_wdata  = word_acc;
            m_strobe = 1'b1;
            words    = (words + 1 > 3) ? 3 : words + 1;
          end
          last_byte = cyc;
        end
      end
      cyc++;
      com_exp = open_at(cyc);
      @(negedge CLK);
      check("strobe",   32'(WriteStrobe), 32'(m_strobe));
      check("wdata",    WriteData, m_wdata);
      check("comact",   32'(ComActive), 32'(com_exp));
      check("phase",    32'(BytePhase), com_exp ? 32'(sess_bytes % 4) : 32'd0);
      check("checksum", 32'(Checksum), 32'(sum));
      check("wcount",   32'(WordCount), 32'(words));
      if (WriteStrobe) seen_words.push_back(WriteData);
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    @(posedge CLK); #1;
    RxValid = v; RxData = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;
    @(negedge CLK);
    check("rst_wdata", WriteData, 32'h0);
    check("rst_comact", 32'(ComActive), 32'h0);
    check("rst_wcount", 32'(WordCount), 32'h0);

    // Sync word on consecutive cycles
    seen_words.delete();
    drive(1'b1, 8'hFA); @(negedge CLK);
    check("t1_com_before", 32'(ComActive), 32'h0);
    drive(1'b1, 8'hB0); @(negedge CLK);
    check("t1_com_rise", 32'(ComActive), 32'h1);
    drive(1'b1, 8'hFA);
    drive(1'b1, 8'hB1);
    drive(1'b0, 8'h00); @(negedge CLK);
    check("t1_strobe", 32'(WriteStrobe), 32'h1);
    check("t1_wdata", WriteData, 32'hFAB0FAB1);
    check("t1_wcount", 32'(WordCount), 32'h1);
    check("t1_checksum", 32'(Checksum), 32'h55);
    drive(1'b0, 8'h00); @(negedge CLK);
    check("t1_strobe_off", 32'(WriteStrobe), 32'h0);
    idle(12);

    // Eight bytes with random short gaps
    seen_words.delete();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8'(i));
      idle($urandom_range(0, 5));
    end
    idle(1); @(negedge CLK);
    check("t2_nwords", seen_words.size(), 32'd2);
    if (seen_words.size() == 2) begin
      check("t2_word0", seen_words[0], 32'h01020304);
      check("t2_word1", seen_words[1], 32'h05060708);
    end
    idle(12);

    // Partial word dropped on timeout
    seen_words.delete();
    drive(1'b1, 8'hAA); drive(1'b1, 8'hBB); drive(1'b1, 8'hCC);
    for (int i = 1; i <= 7; i++) begin
      drive(1'b0, 8'h00); @(negedge CLK);
      check("t3_com_held", 32'(ComActive), 32'h1);
    end
    drive(1'b0, 8'h00); @(negedge CLK);
    check("t3_com_fall", 32'(ComActive), 32'h0);
    check("t3_phase", 32'(BytePhase), 32'h0);
    check("t3_nostrobe", seen_words.size(), 32'd0);
    drive(1'b1, 8'h11); drive(1'b1, 8'h22); drive(1'b1, 8'h33); drive(1'b1, 8'h44);
    drive(1'b0, 8'h00); @(negedge CLK);
    check("t3_wdata", WriteData, 32'h11223344);
    check("t3_checksum", 32'(Checksum), 32'hAA);
    idle(12);

    // Byte on the expiry cycle keeps the session
    drive(1'b1, 8'h55);
    for (int i = 1; i <= 6; i++) begin
      drive(1'b0, 8'h00); @(negedge CLK);
      check("t4_com_held", 32'(ComActive), 32'h1);
    end
    drive(1'b1, 8'h66); @(negedge CLK);
    check("t4_com_expiry", 32'(ComActive), 32'h1);
    drive(1'b0, 8'h00); @(negedge CLK);
    check("t4_com_after", 32'(ComActive), 32'h1);
    check("t4_phase", 32'(BytePhase), 32'h2);
    idle(12);

    // Byte one cycle after expiry starts a new session
    drive(1'b1, 8'h77);
    idle(7);
    drive(1'b1, 8'h88); @(negedge CLK);
    check("t4b_com_gap", 32'(ComActive), 32'h0);
    drive(1'b0, 8'h00); @(negedge CLK);
    check("t4b_com_back", 32'(ComActive), 32'h1);
    check("t4b_phase", 32'(BytePhase), 32'h1);
    check("t4b_checksum", 32'(Checksum), 32'h88);
    idle(12);

    // Reset mid-word
    drive(1'b1, 8'h01); drive(1'b1, 8'h02);
    @(posedge CLK); #1 reset = 1'b1; RxValid = 1'b0;
    @(posedge CLK); #1 reset = 1'b0;
    @(negedge CLK);
    check("t5_wdata", WriteData, 32'h0);
    check("t5_strobe", 32'(WriteStrobe), 32'h0);
    check("t5_comact", 32'(ComActive), 32'h0);
    check("t5_phase", 32'(BytePhase), 32'h0);
    check("t5_checksum", 32'(Checksum), 32'h0);
    check("t5_wcount", 32'(WordCount), 32'h0);
    drive(1'b1, 8'hA1); drive(1'b1, 8'hA2); drive(1'b1, 8'hA3); drive(1'b1, 8'hA4);
    drive(1'b0, 8'h00); @(negedge CLK);
    check("t5_strobe_word", 32'(WriteStrobe), 32'h1);
    check("t5_word", WriteData, 32'hA1A2A3A4);
    idle(12);

    // WordCount saturation with a 2-bit counter
    for (int w = 1; w <= 5; w++) begin
      for (int i = 0; i < 4; i++) begin
        b = 8'(w * 16 + i);
        drive(1'b1, b);
      end
      drive(1'b0, 8'h00); @(negedge CLK);
      check("t6_wcount", 32'(WordCount), (w > 3) ? 32'd3 : 32'(w));
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
